// File: rtl/axi_rd_arb_pkg.sv
// Shared types for the two-port AXI4 read arbiter: AR/R channel payloads
// and the arbiter state encoding.
package axi_rd_arb_pkg;

    localparam int AxiIdWidth   = 4;
    localparam int AxiAddrWidth = 32;
    localparam int AxiDataWidth = 64;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
    } ar_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
    } r_chan_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi_rd_arb_chk.sv
// Simulation-only protocol checks for the read arbiter.
module axi_rd_arb_chk
    import axi_rd_arb_pkg::*;
(
    input logic       clk_i,
    input logic       rst_i,
    input arb_state_e state_i,
    input logic       grant_i,
    input logic       s0_arvalid_i,
    input logic       s1_arvalid_i,
    input logic       m_rvalid_i
);

    // Granted requester must keep arvalid up until its address handshake
    a_arvalid_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_i == ADDR) |-> (grant_i ? s1_arvalid_i : s0_arvalid_i))
        else $error("axi_rd_arb: granted requester dropped arvalid before handshake");

    // Read data is only expected once an address has been issued
    a_rvalid_in_data: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_i != DATA) |-> !m_rvalid_i)
        else $error("axi_rd_arb: rvalid from memory outside the data phase");

endmodule

// File: rtl/axi_rd_arb_pick.sv
// Winner select for the read arbiter. Build option AXI_RD_ARB_RR_EN selects
// round-robin on ties; otherwise FIXED_PRIO_PORT wins ties.
module axi_rd_arb_pick #(
    parameter int FIXED_PRIO_PORT = 1
) (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic winner_o
);

`ifdef AXI_RD_ARB_RR_EN
    // Tie goes to the port that did not own the previous burst
    always_comb begin
        winner_o = 1'b0;
        if (req0_i && req1_i) begin
            winner_o = ~last_grant_i;
        end else if (req1_i) begin
            winner_o = 1'b1;
        end else begin
            winner_o = 1'b0;
        end
    end
`else
    localparam logic PrioPort = (FIXED_PRIO_PORT != 0) ? 1'b1 : 1'b0;

    // Grant history is irrelevant under fixed priority
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant_i;

    // Tie goes to the statically preferred port
    always_comb begin
        winner_o = 1'b0;
        if (req0_i && req1_i) begin
            winner_o = PrioPort;
        end else if (req1_i) begin
            winner_o = 1'b1;
        end else begin
            winner_o = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/axi_rd_arb.sv
// Two-to-one AXI4 read arbiter in front of ssram_ctrl. One burst owns the
// downstream port from address grant until its RLAST beat; an idle cycle
// always separates bursts. Build option: AXI_RD_ARB_RR_EN (round-robin ties).
module axi_rd_arb
    import axi_rd_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int FIXED_PRIO_PORT = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  ar_chan_t s0_ar,
    input  logic     s0_arvalid,
    output logic     s0_arready,
    output r_chan_t  s0_r,
    output logic     s0_rvalid,
    input  logic     s0_rready,
    input  ar_chan_t s1_ar,
    input  logic     s1_arvalid,
    output logic     s1_arready,
    output r_chan_t  s1_r,
    output logic     s1_rvalid,
    input  logic     s1_rready,
    output ar_chan_t m_ar,
    output logic     m_arvalid,
    input  logic     m_arready,
    input  r_chan_t  m_r,
    input  logic     m_rvalid,
    output logic     m_rready,
    output logic     busy
);

    if (NUM_PORTS != 2) begin : g_num_ports_chk
        $error("axi_rd_arb supports exactly two ports");
    end

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic       winner_s;
    logic       sel_arvalid_s;
    logic       sel_rready_s;

    axi_rd_arb_pick #(
        .FIXED_PRIO_PORT(FIXED_PRIO_PORT)
    ) u_pick (
        .req0_i      (s0_arvalid),
        .req1_i      (s1_arvalid),
        .last_grant_i(last_grant_q),
        .winner_o    (winner_s)
    );

    assign sel_arvalid_s = grant_q ? s1_arvalid : s0_arvalid;
    assign sel_rready_s  = grant_q ? s1_rready  : s0_rready;
    assign busy          = (state_q != IDLE);

    // State, current owner and previous owner registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state and combinational routing of AR/R to the granted port
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_ar         = '0;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;
        s0_arready   = 1'b0;
        s1_arready   = 1'b0;
        s0_r         = '0;
        s1_r         = '0;
        s0_rvalid    = 1'b0;
        s1_rvalid    = 1'b0;
        case (state_q)
            IDLE: begin
                if (s0_arvalid || s1_arvalid) begin
                    grant_d = winner_s;
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                m_arvalid = sel_arvalid_s;
                if (grant_q) begin
                    m_ar       = s1_ar;
                    s1_arready = m_arready;
                end else begin
                    m_ar       = s0_ar;
                    s0_arready = m_arready;
                end
                if (sel_arvalid_s && m_arready) begin
                    state_d = DATA;
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                m_rready = sel_rready_s;
                if (grant_q) begin
                    s1_r      = m_r;
                    s1_rvalid = m_rvalid;
                end else begin
                    s0_r      = m_r;
                    s0_rvalid = m_rvalid;
                end
                if (m_rvalid && sel_rready_s && m_r.last) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    axi_rd_arb_chk u_chk (
        .clk_i       (clk),
        .rst_i       (rst),
        .state_i     (state_q),
        .grant_i     (grant_q),
        .s0_arvalid_i(s0_arvalid),
        .s1_arvalid_i(s1_arvalid),
        .m_rvalid_i  (m_rvalid)
    );

endmodule

// File: tb/tb_axi_rd_arb.sv
// Bench for axi_rd_arb: grant table, directed corner cases and random
// traffic checked against a transaction-level model of the arbiter.
module tb_axi_rd_arb;
    import axi_rd_arb_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    ar_chan_t req_ar   [2];
    logic     req_v    [2];
    logic     req_rr   [2];
    logic     arready_o[2];
    r_chan_t  r_o      [2];
    logic     rvalid_o [2];
    ar_chan_t m_ar;
    logic     m_arvalid, m_arready;
    r_chan_t  m_r;
    logic     m_rvalid, m_rready;
    logic     busy;

    always #5 clk = ~clk;

    axi_rd_arb #(.NUM_PORTS(2), .FIXED_PRIO_PORT(1)) dut (
        .clk(clk), .rst(rst),
        .s0_ar(req_ar[0]), .s0_arvalid(req_v[0]), .s0_arready(arready_o[0]),
        .s0_r(r_o[0]), .s0_rvalid(rvalid_o[0]), .s0_rready(req_rr[0]),
        .s1_ar(req_ar[1]), .s1_arvalid(req_v[1]), .s1_arready(arready_o[1]),
        .s1_r(r_o[1]), .s1_rvalid(rvalid_o[1]), .s1_rready(req_rr[1]),
        .m_ar(m_ar), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_r(m_r), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // reference model: who owns the memory port and whether its address went out
    int mdl_owner;
    bit mdl_ar_done;
    bit mdl_last;
    // events seen in the current cycle, applied at the next rising edge
    bit ev_ar_hs, ev_r_hs, ev_r_last;
    int ev_win;
    ar_chan_t ev_ar;
    // requesters
    bit pend[2];
    ar_chan_t issued[2];
    int rbeat[2];
    int beats_got[2];
    int rr_mode[2];
    logic [63:0] last_data[2];
    bit gen_en;
    // memory-side responder
    bit sl_act;
    ar_chan_t sl_ar;
    int sl_beat;
    int sl_hold;
    bit sl_rand_ar, sl_rand_gap;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [31:0] addr, input int beat);
        logic [31:0] b;
        b = 32'(beat);
        return 64'hDEAD_BEEF_0123_4567 ^ {addr - 32'h0000_1000, b};
    endfunction

    // arbitration rule: single requester wins, ties by build option
    function automatic int pick_ref(input bit v0, input bit v1, input bit last);
        if (v0 && v1) begin
`ifdef AXI_RD_ARB_RR_EN
            return last ? 0 : 1;
`else
            return 1;
`endif
        end
        return v1 ? 1 : 0;
    endfunction

    task automatic issue(input int p, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        ar_chan_t a;
        a        = '0;
        a.id     = id;
        a.addr   = addr;
        a.len    = len;
        a.size   = 3'd3;
        a.burst  = 2'b01;
        a.lock   = 1'($urandom);
        a.cache  = 4'($urandom);
        a.prot   = 3'($urandom);
        a.qos    = 4'($urandom);
        a.region = 4'($urandom);
        req_ar[p] = a;
        req_v[p]  = 1'b1;
        pend[p]   = 1'b1;
        issued[p] = a;
        rbeat[p]  = 0;
    endtask

    task automatic tb_reset_state();
        mdl_owner = -1; mdl_ar_done = 1'b0; mdl_last = 1'b1;
        ev_ar_hs = 1'b0; ev_r_hs = 1'b0; ev_r_last = 1'b0; ev_win = -1; ev_ar = '0;
        sl_act = 1'b0; sl_ar = '0; sl_beat = 0; sl_hold = 0;
        sl_rand_ar = 1'b0; sl_rand_gap = 1'b0; gen_en = 1'b0;
        m_arready = 1'b1; m_rvalid = 1'b0; m_r = '0;
        for (int p = 0; p < 2; p++) begin
            req_ar[p] = '0; req_v[p] = 1'b0; req_rr[p] = 1'b1; rr_mode[p] = 0;
            pend[p] = 1'b0; rbeat[p] = 0; beats_got[p] = 0; last_data[p] = '0;
        end
    endtask

    // compare DUT against the model and note this cycle's handshakes
    task automatic sample();
        int o;
        o = mdl_owner;
        chk("busy", 128'(busy), 128'(o >= 0));
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("arready%0d", p), 128'(arready_o[p]),
                128'((o == p && !mdl_ar_done) ? m_arready : 1'b0));
            chk($sformatf("rvalid%0d", p), 128'(rvalid_o[p]),
                128'((o == p && mdl_ar_done) ? m_rvalid : 1'b0));
            if (o == p && mdl_ar_done && m_rvalid)
                chk($sformatf("r_payload%0d", p), 128'(r_o[p]), 128'(m_r));
        end
        if (o < 0) begin
            chk("m_arvalid_idle", 128'(m_arvalid), 128'(0));
            chk("m_rready_idle", 128'(m_rready), 128'(0));
            chk("m_ar_idle", 128'(m_ar), 128'(0));
        end else if (!mdl_ar_done) begin
            chk("m_arvalid_addr", 128'(m_arvalid), 128'(req_v[o]));
            chk("m_ar_addr", 128'(m_ar), 128'(req_ar[o]));
            chk("m_rready_addr", 128'(m_rready), 128'(0));
        end else begin
            chk("m_arvalid_data", 128'(m_arvalid), 128'(0));
            chk("m_rready_data", 128'(m_rready), 128'(req_rr[o]));
        end
        ev_ar_hs  = (o >= 0) && !mdl_ar_done && req_v[o] && m_arready;
        ev_r_hs   = (o >= 0) && mdl_ar_done && m_rvalid && req_rr[o];
        ev_r_last = m_r.last;
        ev_ar     = m_ar;
        ev_win    = (o < 0 && (req_v[0] || req_v[1])) ? pick_ref(req_v[0], req_v[1], mdl_last) : -1;
        if (ev_r_hs) begin
            chk("rid", 128'(r_o[o].id), 128'(issued[o].id));
            chk("rdata", 128'(r_o[o].data), 128'(data_of(issued[o].addr, rbeat[o])));
            chk("rlast", 128'(r_o[o].last), 128'(rbeat[o] == int'(issued[o].len)));
            last_data[o] = r_o[o].data;
        end
    endtask

    // apply the cycle's events to model, requesters and responder; drive new inputs
    task automatic advance();
        int o;
        o = mdl_owner;
        if (ev_win >= 0) begin
            mdl_owner = ev_win; mdl_ar_done = 1'b0;
        end else if (ev_ar_hs) begin
            mdl_ar_done = 1'b1;
        end else if (ev_r_hs && ev_r_last) begin
            mdl_last = (o == 1); mdl_owner = -1;
        end
        if (ev_ar_hs) begin
            req_v[o] = 1'b0; rbeat[o] = 0;
            sl_act = 1'b1; sl_ar = ev_ar; sl_beat = 0;
        end
        if (ev_r_hs) begin
            rbeat[o]++; beats_got[o]++;
            if (ev_r_last) pend[o] = 1'b0;
            if (sl_beat == int'(sl_ar.len)) sl_act = 1'b0;
            else sl_beat++;
        end
        if (!sl_act) begin
            m_rvalid = 1'b0;
            m_r = '0;
        end else begin
            if (!(m_rvalid && !ev_r_hs))
                m_rvalid = !sl_rand_gap || ($urandom_range(0, 2) != 0);
            m_r.id   = sl_ar.id;
            m_r.data = data_of(sl_ar.addr, sl_beat);
            m_r.resp = 2'b00;
            m_r.last = (sl_beat == int'(sl_ar.len));
        end
        if (sl_hold > 0) begin
            sl_hold--; m_arready = 1'b0;
        end else begin
            m_arready = sl_rand_ar ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            case (rr_mode[p])
                1: req_rr[p] = 1'($urandom_range(0, 1));
                2: req_rr[p] = ~req_rr[p];
                default: req_rr[p] = 1'b1;
            endcase
            if (gen_en && !pend[p] && $urandom_range(0, 2) == 0)
                issue(p, $urandom, 8'($urandom_range(0, 3)), 4'($urandom));
        end
    endtask

    task automatic tick();
        sample();
        @(posedge clk);
        #1;
        advance();
        @(negedge clk);
    endtask

    task automatic run_until_idle(input string name, input int maxc);
        int n;
        n = 0;
        while ((pend[0] || pend[1] || mdl_owner >= 0) && n < maxc) begin
            tick();
            n++;
        end
        chk({"drain_", name}, 128'(pend[0] || pend[1] || mdl_owner >= 0), 128'(0));
    endtask

    task automatic chk_all_quiet(input string name);
        chk({name, "_busy"}, 128'(busy), 128'(0));
        chk({name, "_m_arvalid"}, 128'(m_arvalid), 128'(0));
        chk({name, "_m_rready"}, 128'(m_rready), 128'(0));
        chk({name, "_m_ar"}, 128'(m_ar), 128'(0));
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s_arready%0d", name, p), 128'(arready_o[p]), 128'(0));
            chk($sformatf("%s_rvalid%0d", name, p), 128'(rvalid_o[p]), 128'(0));
            chk($sformatf("%s_r%0d", name, p), 128'(r_o[p]), 128'(0));
        end
    endtask

    typedef struct {
        logic v0;
        logic v1;
        int   exp;
    } vec_t;

    initial begin
        vec_t tbl[7];
        ar_chan_t snap;
        int n;
`ifdef AXI_RD_ARB_RR_EN
        tbl = '{'{1'b1, 1'b0, 0}, '{1'b0, 1'b1, 1}, '{1'b1, 1'b1, 0}, '{1'b1, 1'b0, 0},
                '{1'b1, 1'b1, 1}, '{1'b0, 1'b1, 1}, '{1'b1, 1'b1, 0}};
`else
        tbl = '{'{1'b1, 1'b0, 0}, '{1'b0, 1'b1, 1}, '{1'b1, 1'b1, 1}, '{1'b1, 1'b0, 0},
                '{1'b1, 1'b1, 1}, '{1'b0, 1'b1, 1}, '{1'b1, 1'b1, 1}};
`endif
        // reset with busy-looking inputs: outputs must still be quiet
        tb_reset_state();
        rst = 1'b1;
        req_v[0] = 1'b1; req_v[1] = 1'b1; m_rvalid = 1'b1;
        m_r.data = 64'h1234; m_r.last = 1'b1;
        #12;
        chk_all_quiet("reset");
        tb_reset_state();
        @(negedge clk);
        rst = 1'b0;

        // grant table
        for (int i = 0; i < 7; i++) begin
            logic [31:0] a0, a1;
            a0 = 32'h0001_0000 * 32'(i + 1);
            a1 = a0 + 32'h100;
            if (tbl[i].v0) issue(0, a0, 8'd0, 4'd1);
            if (tbl[i].v1) issue(1, a1, 8'd0, 4'd2);
            tick();
            chk($sformatf("tbl%0d_grant_addr", i), 128'(m_ar.addr), 128'(tbl[i].exp == 1 ? a1 : a0));
            run_until_idle($sformatf("tbl%0d", i), 50);
        end

        // port 0 alone, single beat
        beats_got[0] = 0; beats_got[1] = 0;
        issue(0, 32'h0000_1000, 8'd0, 4'd1);
        chk("t1_lat0", 128'(m_arvalid), 128'(0));
        tick();
        chk("t1_lat1", 128'(m_arvalid), 128'(1));
        run_until_idle("t1", 20);
        chk("t1_data", 128'(last_data[0]), 128'(64'hDEAD_BEEF_0123_4567));
        chk("t1_beats0", 128'(beats_got[0]), 128'(1));
        chk("t1_beats1", 128'(beats_got[1]), 128'(0));
        chk("t1_busy_after", 128'(busy), 128'(0));

        // simultaneous requests, port 1 four-beat burst
        beats_got[0] = 0; beats_got[1] = 0;
        issue(0, 32'h0000_2000, 8'd0, 4'd2);
        issue(1, 32'h0000_3000, 8'd3, 4'd5);
        tick();
        chk("t2_first", 128'(m_ar.addr),
            128'(pick_ref(1'b1, 1'b1, mdl_last) == 1 ? 32'h0000_3000 : 32'h0000_2000));
        run_until_idle("t2", 60);
        chk("t2_beats1", 128'(beats_got[1]), 128'(4));
        chk("t2_beats0", 128'(beats_got[0]), 128'(1));

        // back-pressure on port 1 during an 8-beat burst
        beats_got[1] = 0;
        rr_mode[1] = 2;
        issue(1, 32'h0000_4000, 8'd7, 4'd3);
        run_until_idle("t4", 60);
        chk("t4_beats", 128'(beats_got[1]), 128'(8));
        rr_mode[1] = 0; req_rr[1] = 1'b1;

        // address stall: payload held, no data, no grant change
        sl_hold = 10; m_arready = 1'b0;
        issue(1, 32'h0000_5000, 8'd0, 4'd7);
        tick();
        snap = m_ar;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) issue(0, 32'h0000_6000, 8'd1, 4'd8);
            chk("t6_stable", 128'(m_ar), 128'(snap));
            chk("t6_arvalid", 128'(m_arvalid), 128'(1));
            chk("t6_arready0", 128'(arready_o[0]), 128'(0));
            chk("t6_no_r", 128'(rvalid_o[0] | rvalid_o[1]), 128'(0));
            tick();
        end
        run_until_idle("t6", 60);

        // asynchronous reset in the middle of a burst
        beats_got[0] = 0;
        issue(0, 32'h0000_7000, 8'd7, 4'd4);
        n = 0;
        while (beats_got[0] < 2 && n < 40) begin
            tick();
            n++;
        end
        chk("t5_reach_beat2", 128'(beats_got[0]), 128'(2));
        #2;
        rst = 1'b1;
        #1;
        chk_all_quiet("t5_async");
        tb_reset_state();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(0, 32'h0000_8000, 8'd1, 4'd9);
        run_until_idle("t5_after", 30);
        chk("t5_after_beats", 128'(beats_got[0]), 128'(2));

        // random traffic
        sl_rand_ar = 1'b1; sl_rand_gap = 1'b1;
        rr_mode[0] = 1; rr_mode[1] = 1;
        gen_en = 1'b1;
        for (int i = 0; i < 3000; i++) tick();
        gen_en = 1'b0;
        run_until_idle("rand", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arb.md
Name: axi_rd_arb

Overview:
- Two-to-one AXI4 read-channel arbiter placed directly upstream of ssram_ctrl's single read port (AR/R).
- Slave port 0 takes instruction-fetch reads; slave port 1 takes load/store reads.
- Grants one burst at a time and holds the grant until the final R beat. Routes R beats back to the granted requester only.

Parameters:
- NUM_PORTS, 2, number of slave read ports; fixed at 2, any other value fails elaboration.
- FIXED_PRIO_PORT, 1, port that wins simultaneous requests when round-robin is compiled out.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s0_ar  in  ar_chan_t  port-0 AR payload: id, addr, len, size, burst, lock, cache, prot, qos, region.
- s0_arvalid  in  1  port-0 AR valid.
- s0_arready  out  1  port-0 AR ready.
- s0_r  out  r_chan_t  port-0 R payload: id, data[63:0], resp, last.
- s0_rvalid  out  1  port-0 R valid.
- s0_rready  in  1  port-0 R ready.
- s1_ar, s1_arvalid, s1_arready, s1_r, s1_rvalid, s1_rready: same as port 0, for port 1.
- m_ar  out  ar_chan_t  AR payload to ssram_ctrl.
- m_arvalid  out  1  AR valid to ssram_ctrl.
- m_arready  in  1  AR ready from ssram_ctrl.
- m_r  in  r_chan_t  R payload from ssram_ctrl.
- m_rvalid  in  1  R valid from ssram_ctrl.
- m_rready  out  1  R ready to ssram_ctrl.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - state=IDLE, grant=0, last_grant=1.
  - All valid and ready outputs are 0; busy=0.
  - m_ar and s*_r payloads drive 0.
- States and transitions:
  - IDLE: no handshakes accepted.
    - If any s*_arvalid is high: select winner, register grant, go to ADDR.
    - Request-to-m_arvalid latency is 1 cycle.
  - ADDR:
    - m_ar = s[grant]_ar; m_arvalid = s[grant]_arvalid; s[grant]_arready = m_arready.
    - The other port's arready = 0.
    - On m_arvalid & m_arready, go to DATA.
  - DATA:
    - s[grant]_r = m_r; s[grant]_rvalid = m_rvalid; m_rready = s[grant]_rready.
    - The other port's rvalid = 0.
    - On m_rvalid & m_rready & m_r.last: set last_grant = grant, go to IDLE.
- Throughput: one idle cycle between bursts is mandatory.
  - A single-beat read occupies at least 3 cycles: IDLE, ADDR, DATA.
- Pass-through rules:
  - AR and R paths are combinational within ADDR and DATA.
  - No payload is ever modified. ARID and RID pass unchanged.
  - Burst length is handled by ssram_ctrl. This block only watches RLAST.
- A requester dropping arvalid before handshake is an AXI violation and is not supported. An assertion flags it in simulation.
- If rvalid arrives while state is IDLE or ADDR, it is not accepted (m_rready=0). An assertion flags it.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronous). The in-flight burst is abandoned; ssram_ctrl is reset by the same source.
- Simultaneous requests are resolved per the Optional Feature.

Optional Feature:
- Macro: AXI_RD_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both ports request in IDLE, the winner is the port that is not last_grant.
  - A single requester always wins.
- Undefined: fixed priority. FIXED_PRIO_PORT wins ties; last_grant is unused.

Decomposition:
- defs_pkg additions:
  - ar_chan_t packed struct using existing AxiIdWidth.
  - r_chan_t packed struct.
  - arb_state_e enum {IDLE, ADDR, DATA}.
- One sub-module: axi_rd_arb_pick. Purely combinational winner select from the two arvalids, last_grant and the macro; outputs a 1-bit winner.

Test Plan:
- Port 0 alone, araddr=0x0000_1000, len=0: m_arvalid rises 1 cycle after s0_arvalid; single R beat with data 0xDEAD_BEEF_0123_4567 and last=1 reaches s0 only; busy low the next cycle.
- Both ports request in the same cycle, fixed priority (macro off): port 1 burst len=3 completes 4 beats, then port 0 is granted; s0_arready stays 0 throughout port 1's burst.
- Macro on, both ports request continuously for 4 bursts: grants alternate 0,1,0,1 after reset (last_grant=1, so port 0 wins first).
- Back-pressure: s1_rready toggles 1,0,1,0 during a len=7 burst: m_rready tracks it exactly; all 8 beats are delivered in order and RID equals the issued ARID=3.
- Reset asserted in DATA after beat 2 of a len=7 burst: all valids and readies are 0 asynchronously; state is IDLE; a new port-0 request after reset is serviced normally.
- m_arready held low for 10 cycles in ADDR: m_ar stays stable; no R beat is forwarded; the grant does not change.
